// File: rtl/fm_retune_ctrl.sv
// Retune sequencer between reg_map and fmSigMix: mutes audio, slews the NCO
// tuning word to its new target in bounded steps, then restores audio gain.
module fm_retune_ctrl #(
    parameter int unsigned STEP_DIV  = 50,
    parameter logic [31:0] FREQ_STEP = 32'h0000_1000,
    parameter logic [15:0] GAIN_STEP = 16'd64
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_tgt_freq,
    input  logic [15:0] i_tgt_gain,
    input  logic        i_mute_req,
    output logic [31:0] o_rf_freq,
    output logic [15:0] o_audio_gain,
    output logic        o_busy,
    output logic        o_locked
);

    typedef enum logic [1:0] {IDLE, MUTE_DN, SLEW, MUTE_UP} state_t;

    localparam logic [15:0] TICK_LAST = 16'(STEP_DIV - 1);

    state_t      state;
    logic [31:0] tgt_f;
    logic [15:0] tgt_g;
    logic        mute;
    logic [15:0] tick_cnt;
    logic        tick;
    logic [15:0] goal;
    logic [15:0] gain_nxt;
    logic [31:0] freq_nxt;

    // Move cur toward goal by at most step; snapping when close means the
    // unsigned add/subtract can never overshoot or wrap.
    function automatic logic [31:0] ramp32(input logic [31:0] cur,
                                           input logic [31:0] tgt,
                                           input logic [31:0] step);
        logic [31:0] diff;
        diff = (tgt > cur) ? tgt - cur : cur - tgt;
        if (step == '0 || diff <= step)
            return tgt;
        return (tgt > cur) ? cur + step : cur - step;
    endfunction

    function automatic logic [15:0] ramp16(input logic [15:0] cur,
                                           input logic [15:0] tgt,
                                           input logic [15:0] step);
        logic [15:0] diff;
        diff = (tgt > cur) ? tgt - cur : cur - tgt;
        if (step == '0 || diff <= step)
            return tgt;
        return (tgt > cur) ? cur + step : cur - step;
    endfunction

    assign tick = (tick_cnt == TICK_LAST);

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        goal     = tgt_g;
        gain_nxt = o_audio_gain;
        freq_nxt = o_rf_freq;
        if (mute || state == MUTE_DN || state == SLEW)
            goal = '0;
        if (tick) begin
            gain_nxt = ramp16(o_audio_gain, goal, GAIN_STEP);
            if (state == SLEW)
                freq_nxt = ramp32(o_rf_freq, tgt_f, FREQ_STEP);
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples
    // pre-edge values, making a tick at a transition use the old state's rule.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            tgt_f        <= '0;
            tgt_g        <= '0;
            mute         <= 1'b0;
            tick_cnt     <= '0;
            o_rf_freq    <= '0;
            o_audio_gain <= '0;
            o_busy       <= 1'b0;
            o_locked     <= 1'b0;
        end else begin
            tgt_f        <= i_tgt_freq;
            tgt_g        <= i_tgt_gain;
            mute         <= i_mute_req;
            tick_cnt     <= tick ? '0 : tick_cnt + 16'd1;
            o_audio_gain <= gain_nxt;
            o_rf_freq    <= freq_nxt;
            o_busy       <= 1'b1;
            o_locked     <= 1'b0;

            case (state)
                IDLE: begin
                    if (tgt_f != o_rf_freq) begin
                        state <= MUTE_DN;
                    end else begin
                        o_busy   <= 1'b0;
                        o_locked <= 1'b1;
                    end
                end
                MUTE_DN: begin
                    if (o_audio_gain == '0)
                        state <= SLEW;
                end
                SLEW: begin
                    if (o_rf_freq == tgt_f)
                        state <= MUTE_UP;
                end
                MUTE_UP: begin
                    // A fresh retune request outranks finishing the ramp-up.
                    if (tgt_f != o_rf_freq) begin
                        state <= MUTE_DN;
                    end else if (o_audio_gain == goal) begin
                        state    <= IDLE;
                        o_busy   <= 1'b0;
                        o_locked <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fm_retune_ctrl.sv
// Directed bench for fm_retune_ctrl: reset, retunes up/down, mid-slew target
// change, mute in IDLE and asynchronous reset in the middle of a slew.
module tb_fm_retune_ctrl;

    logic        clk;
    logic        rst_n;
    logic [31:0] tgt_freq;
    logic [15:0] tgt_gain;
    logic        mute_req;
    logic [31:0] rf_freq;
    logic [15:0] audio_gain;
    logic        busy;
    logic        locked;

    int n_cmp  = 0;
    int n_fail = 0;

    fm_retune_ctrl #(
        .STEP_DIV (4),
        .FREQ_STEP(32'h100),
        .GAIN_STEP(16'h10)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_tgt_freq  (tgt_freq),
        .i_tgt_gain  (tgt_gain),
        .i_mute_req  (mute_req),
        .o_rf_freq   (rf_freq),
        .o_audio_gain(audio_gain),
        .o_busy      (busy),
        .o_locked    (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for the next gain change; a timeout leaves the old value, which fails.
    task automatic wait_gain(input logic [15:0] exp, input string tag, output int cyc);
        logic [15:0] prev;
        prev = audio_gain;
        cyc  = 0;
        while (audio_gain === prev && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check(tag, 32'(audio_gain), 32'(exp));
    endtask

    task automatic wait_freq(input logic [31:0] exp, input string tag);
        logic [31:0] prev;
        int cyc;
        prev = rf_freq;
        cyc  = 0;
        while (rf_freq === prev && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check(tag, rf_freq, exp);
    endtask

    task automatic wait_idle(input string tag);
        int cyc;
        cyc = 0;
        repeat (2) @(negedge clk);
        while (!(busy === 1'b0 && locked === 1'b1) && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_locked"}, 32'(locked), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic gain_down(input string tag);
        int cyc;
        wait_gain(16'h30, {tag, "_g30"}, cyc);
        wait_gain(16'h20, {tag, "_g20"}, cyc);
        wait_gain(16'h10, {tag, "_g10"}, cyc);
        wait_gain(16'h00, {tag, "_g00"}, cyc);
    endtask

    task automatic gain_up(input string tag);
        int cyc;
        wait_gain(16'h10, {tag, "_g10"}, cyc);
        wait_gain(16'h20, {tag, "_g20"}, cyc);
        wait_gain(16'h30, {tag, "_g30"}, cyc);
        wait_gain(16'h40, {tag, "_g40"}, cyc);
    endtask

    task automatic slew_step(input logic [31:0] exp, input string tag);
        wait_freq(exp, tag);
        check({tag, "_gain0"}, 32'(audio_gain), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd1);
    endtask

    initial begin
        int cyc;

        rst_n    = 1'b0;
        tgt_freq = 32'h0;
        tgt_gain = 16'h40;
        mute_req = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_freq", rf_freq, 32'h0);
        check("rst_gain", 32'(audio_gain), 32'h0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_locked", 32'(locked), 32'd0);

        // 1: release reset; gain ramps up in IDLE, one step every 4 clocks
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("t1_locked", 32'(locked), 32'd1);
        check("t1_busy", 32'(busy), 32'd0);
        wait_gain(16'h10, "t1_g10", cyc);
        wait_gain(16'h20, "t1_g20", cyc);
        check("t1_gap20", 32'(cyc), 32'd4);
        wait_gain(16'h30, "t1_g30", cyc);
        check("t1_gap30", 32'(cyc), 32'd4);
        wait_gain(16'h40, "t1_g40", cyc);
        check("t1_gap40", 32'(cyc), 32'd4);
        check("t1_busy_end", 32'(busy), 32'd0);

        // 2: upward retune 0 -> 0x350
        tgt_freq = 32'h350;
        @(negedge clk);
        check("t2_busy_lat1", 32'(busy), 32'd0);
        @(negedge clk);
        check("t2_busy_lat2", 32'(busy), 32'd1);
        check("t2_unlocked", 32'(locked), 32'd0);
        gain_down("t2");
        slew_step(32'h100, "t2_f100");
        slew_step(32'h200, "t2_f200");
        slew_step(32'h300, "t2_f300");
        slew_step(32'h350, "t2_f350");
        gain_up("t2");
        wait_idle("t2");
        check("t2_final_freq", rf_freq, 32'h350);

        // 3: downward retune 0x350 -> 0x020, final snap
        tgt_freq = 32'h020;
        gain_down("t3");
        slew_step(32'h250, "t3_f250");
        slew_step(32'h150, "t3_f150");
        slew_step(32'h050, "t3_f050");
        slew_step(32'h020, "t3_f020");
        wait_idle("t3");
        check("t3_final_gain", 32'(audio_gain), 32'h40);

        // park at 0 so the next upward slew lands on 0x200
        tgt_freq = 32'h0;
        wait_idle("park");
        check("park_freq", rf_freq, 32'h0);

        // 4: target changes mid-slew; follows from current value without a new mute
        tgt_freq = 32'h350;
        gain_down("t4");
        slew_step(32'h100, "t4_f100");
        slew_step(32'h200, "t4_f200");
        tgt_freq = 32'h180;
        slew_step(32'h180, "t4_f180");
        wait_gain(16'h10, "t4_up_g10", cyc);
        check("t4_up_freq", rf_freq, 32'h180);
        wait_idle("t4");
        check("t4_final_gain", 32'(audio_gain), 32'h40);
        check("t4_final_freq", rf_freq, 32'h180);

        // 5: mute in IDLE ramps gain without leaving IDLE
        mute_req = 1'b1;
        for (int i = 3; i >= 0; i--) begin
            wait_gain(16'(i * 16), "t5_mute_gain", cyc);
            check("t5_mute_busy", 32'(busy), 32'd0);
            check("t5_mute_locked", 32'(locked), 32'd1);
        end
        mute_req = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            wait_gain(16'(i * 16), "t5_unmute_gain", cyc);
            check("t5_unmute_busy", 32'(busy), 32'd0);
        end

        // 6: asynchronous reset mid-slew, then full sequence toward held target
        tgt_freq = 32'h350;
        gain_down("t6");
        slew_step(32'h280, "t6_f280");
        #2 rst_n = 1'b0;
        #1;
        check("t6_async_freq", rf_freq, 32'h0);
        check("t6_async_gain", 32'(audio_gain), 32'h0);
        check("t6_async_busy", 32'(busy), 32'd0);
        check("t6_async_locked", 32'(locked), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        slew_step(32'h100, "t6_f100");
        slew_step(32'h200, "t6_f200");
        slew_step(32'h300, "t6_f300");
        slew_step(32'h350, "t6_f350");
        gain_up("t6");
        wait_idle("t6");
        check("t6_final_freq", rf_freq, 32'h350);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
